// File: rtl/hazard_pkg.sv
// Shared constants for the D-stage hazard/forwarding unit.
package hazard_pkg;

    // Truncated to TW bits at the point of use; all-ones means "operand not read".
    localparam logic [31:0] TUSE_NONE = '1;

    localparam int unsigned TNEW_LINK = 0;
    localparam int unsigned TNEW_ALU  = 1;
    localparam int unsigned TNEW_LOAD = 2;

    localparam int unsigned SEL_RF = 0;

endpackage

// File: rtl/hazard_match.sv
// Priority search of the scoreboard for one D-stage source register.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned AW     = 5,
    parameter int unsigned TW     = 2,
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned SW     = $clog2(NSTAGE + 1)
) (
    input  logic [AW-1:0]             src,
    input  logic [TW-1:0]             tuse,
    input  logic [NSTAGE-1:0][AW-1:0] dst,
    input  logic [NSTAGE-1:0][TW-1:0] tnew,
    output logic                      hit,
    output logic                      stall_term,
    output logic [SW-1:0]             sel
);

    localparam logic [TW-1:0] NONE = TW'(TUSE_NONE);

    // Ascending scan with a found flag: the youngest writer shadows any older one.
    always_comb begin
        hit        = 1'b0;
        stall_term = 1'b0;
        sel        = SW'(SEL_RF);
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            if (!hit && (src != '0) && (dst[k] == src)) begin
                hit        = 1'b1;
                stall_term = (tuse != NONE) && (tnew[k] > tuse);
                sel        = (tnew[k] == '0) ? SW'(k + 1) : SW'(SEL_RF);
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Scoreboard-based stall/forwarding control for the D stage.
// Optional multiply/divide busy counter compiled in with `define MULDIV_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned AW      = 5,
    parameter int unsigned TW      = 2,
    parameter int unsigned NSTAGE  = 3,
    parameter int unsigned SW      = $clog2(NSTAGE + 1),
    parameter int unsigned MUL_CYC = 5,
    parameter int unsigned DIV_CYC = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel
`ifdef MULDIV_EN
    ,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          md_busy
`endif
);

    logic [NSTAGE-1:0][AW-1:0] sb_dst;
    logic [NSTAGE-1:0][TW-1:0] sb_tnew;
    logic rs_hit, rs_term, rt_hit, rt_term, md_term, accept;

    assign accept = d_valid & ~stall;
    assign stall  = d_valid & ((rs_hit & rs_term) | (rt_hit & rt_term) | md_term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_dst  <= '0;
            sb_tnew <= '0;
        end else begin
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                sb_dst[k]  <= sb_dst[k-1];
                sb_tnew[k] <= (sb_tnew[k-1] == '0) ? '0 : sb_tnew[k-1] - TW'(1);
            end
            sb_dst[0]  <= accept ? d_dst  : '0;
            sb_tnew[0] <= accept ? d_tnew : '0;
        end
    end

    hazard_match #(.AW(AW), .TW(TW), .NSTAGE(NSTAGE), .SW(SW)) u_match_rs (
        .src        (d_rs),
        .tuse       (d_tuse_rs),
        .dst        (sb_dst),
        .tnew       (sb_tnew),
        .hit        (rs_hit),
        .stall_term (rs_term),
        .sel        (fwd_rs_sel)
    );

    hazard_match #(.AW(AW), .TW(TW), .NSTAGE(NSTAGE), .SW(SW)) u_match_rt (
        .src        (d_rt),
        .tuse       (d_tuse_rt),
        .dst        (sb_dst),
        .tnew       (sb_tnew),
        .hit        (rt_hit),
        .stall_term (rt_term),
        .sel        (fwd_rt_sel)
    );

`ifdef MULDIV_EN
    localparam int unsigned MW = $clog2(DIV_CYC + 1);

    logic [MW-1:0] md_cnt;

    // Only an accepted start loads; a start held in D by a stall keeps counting down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (accept && d_md_start) begin
            md_cnt <= d_md_div ? MW'(DIV_CYC) : MW'(MUL_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MW'(1);
        end
    end

    assign md_busy = (md_cnt != '0);
    assign md_term = d_md_use & md_busy;
`else
    assign md_term = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and random checks of hazard_unit against an issue-history model.
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int AW     = 5;
    localparam int TW     = 2;
    localparam int NSTAGE = 3;
    localparam int SW     = 2;
    localparam int CMAX   = 4096;
    localparam int NONE   = (1 << TW) - 1;
`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          d_valid;
    logic [AW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic          d_md_start, d_md_div, d_md_use;
    logic          stall;
    logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;
    logic          md_busy;

    always #5 clk = ~clk;

    hazard_unit #(
        .AW(AW), .TW(TW), .NSTAGE(NSTAGE), .SW(SW), .MUL_CYC(5), .DIV_CYC(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel)
`ifdef MULDIV_EN
        ,
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .md_busy    (md_busy)
`endif
    );

    // Model: per issue cycle, what entered E (dst 0 = bubble).
    int acc_dst  [CMAX];
    int acc_tnew [CMAX];
    int cyc;
    int md_start_cyc;
    int md_len;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < CMAX; i++) begin
            acc_dst[i]  = 0;
            acc_tnew[i] = 0;
        end
        md_start_cyc = -1000;
        md_len       = 0;
    endtask

    // An instruction issued k+1 cycles ago sits in stage k with tnew-k cycles still to go.
    function automatic void src_model(input int src, input int tuse, output bit st, output int sel);
        int i;
        int rem;
        st  = 1'b0;
        sel = 0;
        if (src == 0) return;
        for (int k = 0; k < NSTAGE; k++) begin
            i = cyc - 1 - k;
            if (i < 0) return;
            if (acc_dst[i] == src) begin
                rem = acc_tnew[i] - k;
                if (rem < 0) rem = 0;
                st  = (tuse != NONE) && (rem > tuse);
                sel = (rem == 0) ? k + 1 : 0;
                return;
            end
        end
    endfunction

    function automatic int md_rem();
        int r;
        if (md_start_cyc < 0) return 0;
        r = md_len - (cyc - md_start_cyc - 1);
        return (r < 0) ? 0 : r;
    endfunction

    task automatic drive(input int v, input int rs, input int rt, input int tur, input int tut,
                         input int dst, input int tn, input int ms, input int mdv, input int mu);
        d_valid    = v[0];
        d_rs       = AW'(rs);
        d_rt       = AW'(rt);
        d_tuse_rs  = TW'(tur);
        d_tuse_rt  = TW'(tut);
        d_dst      = AW'(dst);
        d_tnew     = TW'(tn);
        d_md_start = ms[0];
        d_md_div   = mdv[0];
        d_md_use   = mu[0];
    endtask

    task automatic check_and_commit(output bit acc, output bit obs_st, output logic [SW-1:0] obs_rs);
        bit st_rs, st_rt, md_term, exp_stall;
        int sel_rs, sel_rt, mr;
        src_model(int'(d_rs), int'(d_tuse_rs), st_rs, sel_rs);
        src_model(int'(d_rt), int'(d_tuse_rt), st_rt, sel_rt);
        mr        = md_rem();
        md_term   = MD && d_md_use && (mr != 0);
        exp_stall = d_valid && (st_rs || st_rt || md_term);
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("fwd_rs_sel", 32'(fwd_rs_sel), 32'(sel_rs));
        chk("fwd_rt_sel", 32'(fwd_rt_sel), 32'(sel_rt));
`ifdef MULDIV_EN
        chk("md_busy", 32'(md_busy), 32'(mr != 0));
`endif
        obs_st       = stall;
        obs_rs       = fwd_rs_sel;
        acc          = d_valid && !exp_stall;
        acc_dst[cyc]  = acc ? int'(d_dst) : 0;
        acc_tnew[cyc] = acc ? int'(d_tnew) : 0;
        if (acc && d_md_start) begin
            md_start_cyc = cyc;
            md_len       = d_md_div ? 10 : 5;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step(input int v, input int rs, input int rt, input int tur, input int tut,
                        input int dst, input int tn, input int ms, input int mdv, input int mu,
                        output bit acc, output bit st, output logic [SW-1:0] srs);
        drive(v, rs, rt, tur, tut, dst, tn, ms, mdv, mu);
        #1;
        check_and_commit(acc, st, srs);
    endtask

    task automatic bubble(input int n);
        bit a, s;
        logic [SW-1:0] r;
        for (int i = 0; i < n; i++) step(0, 0, 0, NONE, NONE, 0, 0, 0, 0, 0, a, s, r);
    endtask

    // Hold one instruction in D until accepted; report DUT stall cycles and rs select at issue.
    task automatic issue(input int rs, input int rt, input int tur, input int tut, input int dst,
                         input int tn, input int ms, input int mdv, input int mu,
                         output int nst, output logic [SW-1:0] sel_acc);
        bit a, s;
        logic [SW-1:0] r;
        nst     = 0;
        sel_acc = '0;
        for (int n = 0; n < 30; n++) begin
            step(1, rs, rt, tur, tut, dst, tn, ms, mdv, mu, a, s, r);
            if (s) nst++;
            if (a) begin
                sel_acc = r;
                return;
            end
        end
        total++;
        bad++;
        $error("FAIL issue_timeout: observed=not_accepted expected=accepted");
    endtask

    int nst;
    logic [SW-1:0] sel;
    bit a, s;
    logic [SW-1:0] r;

    initial begin
        cyc = 0;
        model_clear();
        reset = 1'b1;
        drive(1, 8, 8, 0, 0, 8, TNEW_LOAD, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_rs_sel", 32'(fwd_rs_sel), 32'd0);
        chk("reset_rt_sel", 32'(fwd_rt_sel), 32'd0);
`ifdef MULDIV_EN
        chk("reset_md_busy", 32'(md_busy), 32'd0);
`endif
        drive(0, 0, 0, NONE, NONE, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // lw $8 then addu reading $8 at tuse 0
        issue(0, 0, NONE, NONE, 8, TNEW_LOAD, 0, 0, 0, nst, sel);
        issue(8, 0, 0, NONE, 9, TNEW_ALU, 0, 0, 0, nst, sel);
        chk("lw_tuse0_stalls", 32'(nst), 32'd2);
        chk("lw_tuse0_fwd", 32'(sel), 32'd3);
        bubble(4);

        // lw $8 then a tuse-1 reader
        issue(0, 0, NONE, NONE, 8, TNEW_LOAD, 0, 0, 0, nst, sel);
        issue(8, 0, 1, NONE, 10, TNEW_ALU, 0, 0, 0, nst, sel);
        chk("lw_tuse1_stalls", 32'(nst), 32'd1);
        chk("lw_tuse1_fwd", 32'(sel), 32'd0);
        bubble(4);

        // ori $9 then beq $9
        issue(0, 0, NONE, NONE, 9, TNEW_ALU, 0, 0, 0, nst, sel);
        issue(9, 0, 0, 0, 0, TNEW_LINK, 0, 0, 0, nst, sel);
        chk("alu_stalls", 32'(nst), 32'd1);
        chk("alu_fwd", 32'(sel), 32'd2);
        bubble(4);
        issue(0, 0, NONE, NONE, 9, TNEW_ALU, 0, 0, 0, nst, sel);
        issue(0, 0, 0, 0, 0, TNEW_LINK, 0, 0, 0, nst, sel);
        chk("r0_stalls", 32'(nst), 32'd0);
        chk("r0_fwd", 32'(sel), 32'd0);
        bubble(4);

        // addu $5, lw $5, reader of $5: younger load dominates
        issue(0, 0, NONE, NONE, 5, TNEW_ALU, 0, 0, 0, nst, sel);
        issue(0, 0, NONE, NONE, 5, TNEW_LOAD, 0, 0, 0, nst, sel);
        issue(5, 0, 0, NONE, 11, TNEW_ALU, 0, 0, 0, nst, sel);
        chk("younger_stalls", 32'(nst), 32'd2);
        chk("younger_fwd", 32'(sel), 32'd3);
        bubble(4);

`ifdef MULDIV_EN
        issue(0, 0, NONE, NONE, 0, 0, 1, 1, 1, nst, sel);
        issue(0, 0, NONE, NONE, 12, TNEW_ALU, 0, 0, 1, nst, sel);
        chk("div_stalls", 32'(nst), 32'd10);
        bubble(12);
        issue(0, 0, NONE, NONE, 0, 0, 1, 0, 1, nst, sel);
        issue(0, 0, NONE, NONE, 12, TNEW_ALU, 0, 0, 1, nst, sel);
        chk("mult_stalls", 32'(nst), 32'd5);
        bubble(8);
        issue(0, 0, NONE, NONE, 8, TNEW_LOAD, 0, 0, 0, nst, sel);
        issue(8, 0, 0, NONE, 0, 0, 1, 0, 1, nst, sel);
        chk("mult_after_lw_stalls", 32'(nst), 32'd2);
        issue(0, 0, NONE, NONE, 12, TNEW_ALU, 0, 0, 1, nst, sel);
        chk("mult_late_load_stalls", 32'(nst), 32'd5);
        bubble(8);
        issue(0, 0, NONE, NONE, 0, 0, 1, 1, 1, nst, sel);
`endif

        // Reset mid-stream with a lw in E
        issue(0, 0, NONE, NONE, 8, TNEW_LOAD, 0, 0, 0, nst, sel);
        drive(1, 8, 0, 0, NONE, 9, TNEW_ALU, 0, 0, 1);
        #1;
        chk("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_stall", 32'(stall), 32'd0);
        chk("async_reset_rs_sel", 32'(fwd_rs_sel), 32'd0);
        chk("async_reset_rt_sel", 32'(fwd_rt_sel), 32'd0);
`ifdef MULDIV_EN
        chk("async_reset_md_busy", 32'(md_busy), 32'd0);
`endif
        drive(0, 0, 0, NONE, NONE, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        issue(8, 0, 0, NONE, 9, TNEW_ALU, 0, 0, 0, nst, sel);
        chk("post_reset_stalls", 32'(nst), 32'd0);
        chk("post_reset_fwd", 32'(sel), 32'd0);

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 500; i++) begin
            int ms;
            ms = ($urandom_range(0, 19) == 0) ? 1 : 0;
            step(($urandom_range(0, 9) != 0) ? 1 : 0,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2),
                 ms, $urandom_range(0, 1),
                 (ms == 1 || $urandom_range(0, 9) == 0) ? 1 : 0,
                 a, s, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
